multicycle_ctrl: RTL

Multi-cycle control FSM for the MIPS datapath built around `IM`, `RF` and `DM`. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every write enable, mux select and ALU operation so that one shared ALU and one memory port per array can serve the whole instruction. It sits beside the datapath in the CPU top and consumes only the instruction-register fields and the ALU zero flag.

---
 rtl/multicycle_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: IF/ID/EX/MEM/WB sequencing with decode-driven datapath controls.
// Optional CTRL_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        rf_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        dm_read,
  output logic        dm_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic        illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam int unsigned CNT_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic       is_rtype, is_lw, is_sw, is_beq, is_addi, is_j;
  logic       r_legal, op_legal;
  logic [3:0] r_alu;

  // Instruction decode from the IR fields
  always_comb begin
    is_rtype = (opcode == OP_RTYPE);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_beq   = (opcode == OP_BEQ);
    is_addi  = (opcode == OP_ADDI);
    is_j     = (opcode == OP_J);
    r_legal  = 1'b1;
    case (funct)
      6'h20:   r_alu = ALU_ADD;
      6'h22:   r_alu = ALU_SUB;
      6'h24:   r_alu = ALU_AND;
      6'h25:   r_alu = ALU_OR;
      6'h27:   r_alu = ALU_NOR;
      6'h2A:   r_alu = ALU_SLT;
      default: begin
        r_alu   = 4'b0000;
        r_legal = 1'b0;
      end
    endcase
    op_legal = (is_rtype && r_legal) || is_lw || is_sw || is_beq || is_addi || is_j;
  end

  // Next state and per-state controls; reset forces every output low
  always_comb begin
    state_d    = S_IF;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    rf_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    dm_read    = 1'b0;
    dm_write   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = 4'b0000;
    instr_done = 1'b0;
    illegal    = 1'b0;
    state      = 3'(state_q);

    case (state_q)
      S_IF: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        state_d   = S_ID;
      end
      S_ID: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        if (!op_legal) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end else if (is_j) begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        alu_src_a = 1'b1;
        if (is_rtype) begin
          alu_ctrl = r_alu;
          state_d  = S_WB;
        end else if (is_lw || is_sw || is_addi) begin
          alu_src_b = 2'b10;
          alu_ctrl  = ALU_ADD;
          state_d   = is_addi ? S_WB : S_MEM;
        end else if (is_beq) begin
          alu_ctrl   = ALU_SUB;
          pc_src     = 2'b01;
          pc_write   = zero;
          instr_done = 1'b1;
        end else begin
          alu_src_a = 1'b0;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          dm_read = 1'b1;
          state_d = S_WB;
        end else if (is_sw) begin
          dm_write   = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_WB: begin
        rf_write   = 1'b1;
        instr_done = 1'b1;
        reg_dst    = is_rtype;
        mem_to_reg = is_lw;
      end
      default: state_d = S_IF;
    endcase

    if (rst) begin
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      rf_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      dm_read    = 1'b0;
      dm_write   = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = 4'b0000;
      instr_done = 1'b0;
      illegal    = 1'b0;
      state      = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  // Free-running counters, wrapping naturally at 2^32
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    instr_cnt_d = instr_cnt_q + CNT_W'(instr_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule
